// File: rtl/fir_mac_sequencer_pkg.sv
// rtl/fir_mac_sequencer_pkg.sv - Q1.6 format constants, saturation helper and FSM states for the FIR sequencer
package fir_mac_sequencer_pkg;

  localparam int SAMPLE_W  = 8;
  localparam int FRAC_BITS = 6;
  localparam int PROD_W    = 16;
  localparam int Q_MAX     = 127;
  localparam int Q_MIN     = -128;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                sat;
  } sat_t;

  // Clip a wide signed value into the Q1.6 range and flag whether clipping happened.
  function automatic sat_t saturate_q16(input logic signed [31:0] v);
    sat_t r;
    if (v > Q_MAX) begin
      r.data = SAMPLE_W'(Q_MAX);
      r.sat  = 1'b1;
    end else if (v < Q_MIN) begin
      r.data = SAMPLE_W'(Q_MIN);
      r.sat  = 1'b1;
    end else begin
      r.data = v[SAMPLE_W-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/Multiplier_Fixed8x8.sv
// rtl/Multiplier_Fixed8x8.sv - signed Q1.6 x Q1.6 multiplier, product floor-shifted back to Q1.6 scale
module Multiplier_Fixed8x8
  import fir_mac_sequencer_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] a_i,
  input  logic signed [SAMPLE_W-1:0] b_i,
  output logic signed [PROD_W-1:0]   p_o
);

  logic signed [PROD_W-1:0] full;

  assign full = a_i * b_i;
  // Arithmetic shift gives floor rounding, so P(-1, 1) = -1.
  assign p_o  = full >>> FRAC_BITS;

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR filter sequencing one shared Q1.6 multiplier over all taps
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int ACC_W = 16,
  parameter int AW    = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic [SAMPLE_W-1:0] coef_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_sat,
  output logic                busy
);

  state_t                  state_q, state_d;
  sample_t                 x_q [TAPS];
  sample_t                 x_d [TAPS];
  sample_t                 h_q [TAPS];
  sample_t                 h_d [TAPS];
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [AW-1:0]           k_q, k_d;
  logic [SAMPLE_W-1:0]     out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic signed [PROD_W-1:0] prod;
  logic                    accept, last_tap, coef_wr_ok;
  sat_t                    sat_res;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_tap   = (k_q == AW'(TAPS - 1));
  assign coef_wr_ok = coef_we && (state_q == IDLE) && (int'(coef_addr) < TAPS);

  Multiplier_Fixed8x8 u_mult (
    .a_i (h_q[k_q]),
    .b_i (x_q[k_q]),
    .p_o (prod)
  );

  // The final result is taken from the sum including the last product, not from acc_q.
  assign acc_sum = acc_q + ACC_W'(prod);
  assign sat_res = saturate_q16(32'(acc_sum));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = MAC;
      MAC:     if (last_tap)  state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

  always_comb begin
    x_d        = x_q;
    h_d        = h_q;
    acc_d      = acc_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    // A write in the accept cycle lands before the first MAC cycle reads the bank.
    if (coef_wr_ok) begin
      h_d[coef_addr] = coef_wdata;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0] = in_data;
          acc_d  = '0;
          k_d    = '0;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (last_tap) begin
          k_d        = '0;
          out_data_d = sat_res.data;
          out_sat_d  = sat_res.sat;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      k_q        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      acc_q      <= acc_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      x_q        <= x_d;
      h_q        <= h_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - self-checking bench for fir_mac_sequencer against a behavioural FIR model
module tb_fir_mac_sequencer;

  localparam int TAPS  = 8;
  localparam int ACC_W = 16;
  localparam int AW    = $clog2(TAPS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [7:0]    coef_wdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_sat;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  int hist [TAPS];
  int coef [TAPS];

  typedef struct {
    int x;
    int exp_d;
    int exp_s;
  } vec_t;

  vec_t vecs [TAPS];

  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      coef[i] = 0;
    end
  endfunction

  function automatic void model_shift(input int x);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic int model_raw();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += (coef[k] * hist[k]) >>> 6;
    return s;
  endfunction

  function automatic int clip(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  task automatic write_coef(input int k, input int v);
    coef_we = 1'b1;
    coef_addr = AW'(k);
    coef_wdata = 8'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    coef[k] = v;
  endtask

  // mode 0: plain sample; 1: write h[2]=64 in the accept cycle; 2: same write during MAC
  task automatic do_sample(input int x, input int mode, input string tag,
                           output int got_d, output int got_s);
    int lat;
    int raw;
    if (mode == 1) begin
      coef_we = 1'b1; coef_addr = AW'(2); coef_wdata = 8'd64;
      coef[2] = 64;
    end
    in_valid = 1'b1;
    in_data = 8'(x);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    model_shift(x);
    raw = model_raw();
    if (mode == 2) begin
      coef_we = 1'b1; coef_addr = AW'(2); coef_wdata = 8'd64;
    end
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
      coef_we = 1'b0;
    end
    got_d = int'($signed(out_data));
    got_s = int'(out_sat);
    chk({tag, " latency"}, lat, TAPS);
    chk({tag, " data"}, got_d, clip(raw));
    chk({tag, " sat"}, got_s, int'(raw != clip(raw)));
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    int gd, gs, d0, s0, bad, raw, lat;
    int acc_cnt, out_cnt, cyc, last_acc;
    int smp [4];
    int exp_d_q [$];
    int exp_s_q [$];

    for (int i = 0; i < TAPS; i++) begin
      vecs[i].x     = (i == 0) ? 64 : 0;
      vecs[i].exp_d = 8 * i;
      vecs[i].exp_s = 0;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < TAPS; k++) write_coef(k, 8 * k);
    for (int i = 0; i < TAPS; i++) begin
      do_sample(vecs[i].x, 0, "impulse", gd, gs);
      chk("impulse table data", gd, vecs[i].exp_d);
      chk("impulse table sat", gs, vecs[i].exp_s);
    end

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
      do_sample(int'($urandom_range(0, 255)) - 128, 0, "random", gd, gs);
    end

    write_coef(2, -32);
    do_sample(64, 2, "prot mac write", gd, gs);
    do_sample(0, 0, "prot readback1", gd, gs);
    do_sample(0, 0, "prot readback2", gd, gs);
    do_sample(50, 1, "prot idle write", gd, gs);
    do_sample(0, 0, "prot idle follow", gd, gs);

    // Backpressure: result held for 5 cycles while the next sample waits on in_valid.
    in_valid = 1'b1;
    in_data = 8'(-77);
    @(posedge clk); #1;
    model_shift(-77);
    raw = model_raw();
    in_data = 8'(91);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    d0 = int'($signed(out_data));
    s0 = int'(out_sat);
    chk("bp latency", lat, TAPS);
    chk("bp data", d0, clip(raw));
    chk("bp sat", s0, int'(raw != clip(raw)));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold valid", int'(out_valid), 1);
      chk("bp hold data", int'($signed(out_data)), d0);
      chk("bp hold sat", int'(out_sat), s0);
      chk("bp hold in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", int'(out_valid), 0);
    chk("bp release in_ready", int'(in_ready), 1);
    chk("bp release busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("bp next accepted", int'(busy), 1);
    in_valid = 1'b0;
    model_shift(91);
    raw = model_raw();
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp next latency", lat, TAPS);
    chk("bp next data", int'($signed(out_data)), clip(raw));
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Throughput: in_valid and out_ready both held high.
    for (int i = 0; i < 4; i++) smp[i] = int'($urandom_range(0, 255)) - 128;
    acc_cnt = 0; out_cnt = 0; cyc = 0; last_acc = 0;
    in_data = 8'(smp[0]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (out_cnt < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        chk("thru data", int'($signed(out_data)), exp_d_q.pop_front());
        chk("thru sat", int'(out_sat), exp_s_q.pop_front());
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        if (acc_cnt > 0) chk("thru spacing", cyc - last_acc, TAPS + 2);
        last_acc = cyc;
        model_shift(smp[acc_cnt]);
        raw = model_raw();
        exp_d_q.push_back(clip(raw));
        exp_s_q.push_back(int'(raw != clip(raw)));
        acc_cnt++;
        @(posedge clk); #1;
        if (acc_cnt < 4) in_data = 8'(smp[acc_cnt]);
        else in_valid = 1'b0;
      end
    end
    chk("thru result count", out_cnt, 4);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of MAC abandons the computation and clears history.
    in_valid = 1'b1;
    in_data = 8'(37);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid-mac rst out_valid", int'(out_valid), 0);
    chk("mid-mac rst in_ready", int'(in_ready), 1);
    chk("mid-mac rst out_data", int'(out_data), 0);
    chk("mid-mac rst busy", int'(busy), 0);
    #2;
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1;
    end
    chk("mid-mac rst no partial output", bad, 0);
    out_ready = 1'b0;
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    do_sample(64, 0, "post-rst impulse", gd, gs);
    chk("post-rst zero history", gd, 1);

    pulse_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    do_sample(127, 0, "sat pos", gd, gs);
    chk("sat pos clip data", gd, 127);
    chk("sat pos clip flag", gs, 1);
    pulse_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    do_sample(-128, 0, "sat neg", gd, gs);
    chk("sat neg clip data", gd, -128);
    chk("sat neg clip flag", gs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
